// File: rtl/fm_ctrl.sv
// Frame-memory controller: unpacks 4-pixel words, reads each pixel's stored
// background/variance, hands it to the datapath and writes the update back.
module fm_ctrl #(
  parameter int         FRAME_PIXELS = 76800,
  parameter int         ADDR_W       = 17,
  parameter logic [7:0] VAR_INIT     = 8'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pixel,
  input  logic              last_in_frame,
  output logic [7:0]        curr_pixel,
  output logic [7:0]        prev_pixel,
  output logic [7:0]        prev_variance,
  output logic              px_valid,
  input  logic              wr_background,
  input  logic [7:0]        background_next,
  input  logic [7:0]        variance_next,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, RD, RSP, WAITWB, WR} state_t;

  localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [31:0]       word_q;
  logic              last_q;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   addr_inc;
  logic              first_frame;
  logic              overrun;
  logic              done_q;
  logic              err_q;
  logic [7:0]        lane_byte;
  logic              word_end;
  logic              frame_end;
  logic              addr_wrap;

  assign lane_byte = word_q[{lane, 3'b000} +: 8];
  assign addr_inc  = {1'b0, addr} + ADDR_ONE;
  assign word_end  = (lane == 2'd3);
  assign frame_end = word_end && last_q;
  // Running past the frame length without a frame marker wraps the address.
  assign addr_wrap = !frame_end && (addr_inc == FRAME_LEN);

  // NOTE: state and all registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    state_next = RD;
      RD:      state_next = RSP;
      RSP:     state_next = WAITWB;
      WAITWB:  if (wr_background) state_next = WR;
      WR: begin
        if (!word_end)     state_next = RD;
        else if (in_valid) state_next = LOAD;
        else               state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q        <= '0;
      last_q        <= 1'b0;
      lane          <= '0;
      addr          <= '0;
      first_frame   <= 1'b1;
      overrun       <= 1'b0;
      frame_cnt     <= '0;
      curr_pixel    <= '0;
      prev_pixel    <= '0;
      prev_variance <= '0;
      mem_wdata     <= '0;
    end else if (enable) begin
      case (state)
        LOAD: begin
          word_q <= pixel;
          last_q <= last_in_frame;
          lane   <= '0;
        end
        RSP: begin
          // The first frame has no valid background yet, so seed it from the pixel.
          curr_pixel    <= lane_byte;
          prev_pixel    <= first_frame ? lane_byte : mem_rdata[7:0];
          prev_variance <= first_frame ? VAR_INIT : mem_rdata[15:8];
        end
        WAITWB: begin
          if (wr_background) mem_wdata <= {variance_next, background_next};
        end
        WR: begin
          if (!word_end) lane <= lane + 2'd1;
          if (frame_end) begin
            addr        <= '0;
            frame_cnt   <= frame_cnt + 16'd1;
            first_frame <= 1'b0;
            overrun     <= 1'b0;
          end else if (addr_wrap) begin
            addr    <= '0;
            overrun <= 1'b1;
          end else begin
            addr <= addr_inc[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Status pulses are never frozen: they last exactly one cycle after the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= enable && (state == WR) && frame_end;
      err_q  <= enable && (state == WR) &&
                (frame_end ? (overrun || (addr_inc != FRAME_LEN)) : addr_wrap);
    end
  end

  assign in_ready   = enable && (state == LOAD);
  assign mem_en     = enable && ((state == RD) || (state == WR));
  assign mem_we     = enable && (state == WR);
  assign mem_addr   = addr;
  assign px_valid   = (state == WAITWB);
  assign frame_done = enable && done_q;
  assign frame_err  = enable && err_q;

endmodule

// File: tb/tb_fm_ctrl.sv
// Directed and randomized bench for fm_ctrl against a per-pixel reference
// model of the expected background store and frame accounting.
module tb_fm_ctrl;

  localparam int         FP       = 8;
  localparam int         AW       = 4;
  localparam logic [7:0] VAR_INIT = 8'd16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          last_in_frame = 1'b0;
  logic          wr_background = 1'b0;
  logic [31:0]   pixel = '0;
  logic [7:0]    background_next = '0;
  logic [7:0]    variance_next = '0;
  logic          in_ready, px_valid, mem_en, mem_we, frame_done, frame_err;
  logic [7:0]    curr_pixel, prev_pixel, prev_variance;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, frame_cnt;
  logic [15:0]   mem_rdata;

  fm_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW), .VAR_INIT(VAR_INIT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .last_in_frame(last_in_frame),
    .curr_pixel(curr_pixel), .prev_pixel(prev_pixel), .prev_variance(prev_variance),
    .px_valid(px_valid), .wr_background(wr_background),
    .background_next(background_next), .variance_next(variance_next),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  logic [15:0] mem [16];
  int wr_count = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_count      <= wr_count + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Reference model: what the background store should hold per address.
  bit [7:0] ref_bg  [FP];
  bit [7:0] ref_var [FP];
  int ref_addr, ref_pix, ref_cnt;
  bit ref_first;
  int fix_addr;
  bit [7:0] fix_bg, fix_var;
  int ready_cyc;
  int checks, errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 normal, 1 freeze in lane 1 WAITWB, 2 reset in lane 1 WAITWB.
  task automatic do_word(input logic [31:0] w, input bit last, input bit keep,
                         input int dly, input bit spur, input int mode, input bit chk_gap);
    int n;
    logic [7:0] cur, ep, ev, bg, vr;
    bit edone, eerr;
    in_valid = 1'b1; pixel = w; last_in_frame = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", 32'(in_ready), 32'd1);
    if (chk_gap) check("ready_gap", 32'(cyc - ready_cyc), 32'd17);
    ready_cyc = cyc;
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    for (int lane = 0; lane < 4; lane++) begin
      check("rd_strobe", 32'({mem_en, mem_we}), 32'b10);
      check("rd_addr", 32'(mem_addr), 32'(ref_addr));
      if (spur) wr_background = 1'b1;
      @(negedge clk);
      wr_background = 1'b0;
      check("rsp_idle", 32'({px_valid, mem_en}), 32'b00);
      @(negedge clk);
      cur = w[lane*8 +: 8];
      ep  = ref_first ? cur : ref_bg[ref_addr];
      ev  = ref_first ? VAR_INIT : ref_var[ref_addr];
      check("px_valid", 32'(px_valid), 32'd1);
      check("curr_pixel", 32'(curr_pixel), 32'(cur));
      check("prev_pixel", 32'(prev_pixel), 32'(ep));
      check("prev_variance", 32'(prev_variance), 32'(ev));
      check("wait_mem_en", 32'(mem_en), 32'd0);
      bg = (ref_addr == fix_addr) ? fix_bg  : 8'($urandom);
      vr = (ref_addr == fix_addr) ? fix_var : 8'($urandom);
      if (mode == 2 && lane == 1) begin
        n = wr_count;
        rst = 1'b0;
        #1;
        check("rst_ctrl", 32'({px_valid, in_ready, mem_en, mem_we, frame_done, frame_err}), 32'd0);
        check("rst_data", 32'({curr_pixel, prev_pixel, prev_variance}), 32'd0);
        check("rst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_nowrite", 32'(wr_count), 32'(n));
        rst = 1'b1;
        ref_first = 1'b1; ref_addr = 0; ref_pix = 0; ref_cnt = 0;
        return;
      end
      if (mode == 1 && lane == 1) begin
        background_next = bg; variance_next = vr;
        wr_background = 1'b1;
        enable = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("frz_px_valid", 32'(px_valid), 32'd1);
          check("frz_data", 32'({curr_pixel, prev_pixel, prev_variance}), 32'({cur, ep, ev}));
          check("frz_strobes", 32'({mem_en, in_ready, frame_done, frame_err}), 32'd0);
        end
        enable = 1'b1;
      end else begin
        for (int d = 0; d < dly; d++) begin
          @(negedge clk);
          check("stall_px_valid", 32'(px_valid), 32'd1);
          check("stall_data", 32'({curr_pixel, prev_pixel, prev_variance}), 32'({cur, ep, ev}));
          check("stall_mem_en", 32'(mem_en), 32'd0);
        end
        background_next = bg; variance_next = vr;
        wr_background = 1'b1;
      end
      @(negedge clk);
      wr_background = 1'b0;
      check("wr_strobe", 32'({mem_en, mem_we}), 32'b11);
      check("wr_addr", 32'(mem_addr), 32'(ref_addr));
      check("wr_data", 32'(mem_wdata), 32'({vr, bg}));
      ref_bg[ref_addr] = bg; ref_var[ref_addr] = vr;
      ref_pix++; ref_addr++;
      edone = 1'b0; eerr = 1'b0;
      if (lane == 3 && last) begin
        edone = 1'b1; eerr = (ref_pix != FP);
        ref_addr = 0; ref_pix = 0; ref_cnt++; ref_first = 1'b0;
      end else if (ref_addr == FP) begin
        eerr = 1'b1; ref_addr = 0;
      end
      @(negedge clk);
      if (lane == 3) begin
        check("frame_done", 32'(frame_done), 32'(edone));
        check("frame_err", 32'(frame_err), 32'(eerr));
        check("frame_cnt", 32'(frame_cnt), 32'(ref_cnt[15:0]));
      end else begin
        check("mid_pulses", 32'({frame_done, frame_err}), 32'd0);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    ref_first = 1'b1; ref_addr = 0; ref_pix = 0; ref_cnt = 0;
    fix_addr = -1; fix_bg = '0; fix_var = '0; ready_cyc = 0;
    for (int i = 0; i < FP; i++) begin ref_bg[i] = '0; ref_var[i] = '0; end
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'({in_ready, px_valid, mem_en, mem_we, frame_done, frame_err}), 32'd0);
    check("reset_cnt", 32'(frame_cnt), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1; enable = 1'b1;
    @(negedge clk);

    // First frame: immediate acks, back-to-back words, address 0 seeded with 0x0A50.
    fix_addr = 0; fix_bg = 8'h50; fix_var = 8'h0A;
    do_word(32'h44332211, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    do_word($urandom, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);

    // Second frame: stored values come back; stall with a spurious ack in RD; freeze.
    fix_bg = 8'h52; fix_var = 8'h0B;
    do_word($urandom, 1'b0, 1'b0, 5, 1'b1, 0, 1'b0);
    fix_addr = -1;
    do_word($urandom, 1'b1, 1'b0, 1, 1'b0, 1, 1'b0);

    // Three-word frame: wrap error after word 1, done+error on word 2.
    do_word($urandom, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    do_word($urandom, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1);
    do_word($urandom, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);

    // Reset mid-pixel, then the following frame is treated as the first again.
    do_word($urandom, 1'b0, 1'b0, 0, 1'b0, 2, 1'b0);
    do_word($urandom, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    do_word($urandom, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);

    for (int f = 0; f < 8; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++)
        do_word($urandom, (k == nw - 1), (k != nw - 1) && ($urandom_range(0, 1) == 1),
                $urandom_range(0, 3), ($urandom_range(0, 1) == 1), 0, 1'b0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
